// File: rtl/bp_be_ptw_pkg.sv
// Shared types and constants for the backend page-table walker.
package bp_be_ptw_pkg;

   localparam int bp_vpn_seg_width_lp    = 9;
   localparam int bp_page_offset_width_lp = 12;
   localparam int bp_pte_size_log_lp     = 3;

   typedef struct packed {
      logic [9:0]  reserved;
      logic [43:0] ppn;
      logic [1:0]  rsw;
      logic        d;
      logic        a;
      logic        g;
      logic        u;
      logic        x;
      logic        w;
      logic        r;
      logic        v;
   } bp_sv39_pte_s;

   typedef enum logic [2:0] {IDLE, SEND, WAIT, FILL, FAULT} bp_ptw_state_e;

endpackage

// File: rtl/bp_be_pte_decode.sv
// Combinational PTE decode: classifies one PTE at a given level and forms the
// next-level table PPN or the final (possibly superpage) translation.
module bp_be_pte_decode
   import bp_be_ptw_pkg::*;
#(
   parameter int ptag_width_p = 28,
   parameter int vtag_width_p = 27,
   parameter int pte_width_p  = 64,
   parameter int lvl_width_p  = 2,
   parameter int seg_width_p  = 9
) (
   input  logic [pte_width_p-1:0]  pte_i,
   input  logic [lvl_width_p-1:0]  level_i,
   input  logic [vtag_width_p-1:0] vtag_i,
   output logic                    fault_o,
   output logic                    leaf_o,
   output logic [ptag_width_p-1:0] next_ppn_o,
   output logic [ptag_width_p-1:0] leaf_ptag_o
);

   bp_sv39_pte_s            pte_s;
   logic [ptag_width_p-1:0] ppn;
   logic [ptag_width_p-1:0] lvl_mask;
   logic                    misaligned;
   logic                    unused;

   assign pte_s  = bp_sv39_pte_s'(pte_i[63:0]);
   assign unused = ^pte_s[63:8];
   assign ppn    = pte_i[10 +: ptag_width_p];

   // Low PPN bits that a superpage at this level must leave clear; they come
   // from the virtual address instead.
   assign lvl_mask   = ~({ptag_width_p{1'b1}} << (int'(level_i) * seg_width_p));
   assign misaligned = |(ppn & lvl_mask);

   assign leaf_o      = pte_s.r | pte_s.x;
   assign next_ppn_o  = ppn;
   assign leaf_ptag_o = (ppn & ~lvl_mask) | (ptag_width_p'(vtag_i) & lvl_mask);

   assign fault_o = ~pte_s.v
                  | (~pte_s.r & pte_s.w)
                  | (leaf_o & misaligned)
                  | (~leaf_o & (level_i == '0));

endmodule

// File: rtl/bp_be_ptw.sv
// Sv39-style page-table walker: turns a TLB miss into a sequence of PTE reads,
// then emits either a TLB fill pulse or a page-fault pulse.
module bp_be_ptw
   import bp_be_ptw_pkg::*;
#(
   parameter int vtag_width_p       = 27,
   parameter int ptag_width_p       = 28,
   parameter int page_table_depth_p = 3,
   parameter int pte_width_p        = 64,
   parameter int paddr_width_p      = 40
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [ptag_width_p-1:0]  base_ppn_i,
   input  logic                     miss_v_i,
   input  logic [vtag_width_p-1:0]  miss_vtag_i,
   output logic                     busy_o,
   output logic                     mem_req_v_o,
   output logic [paddr_width_p-1:0] mem_req_addr_o,
   input  logic                     mem_req_ready_i,
   input  logic                     mem_resp_v_i,
   input  logic [pte_width_p-1:0]   mem_resp_data_i,
   output logic                     tlb_w_v_o,
   output logic [vtag_width_p-1:0]  tlb_w_vtag_o,
   output logic [ptag_width_p-1:0]  tlb_w_ptag_o,
   output logic                     page_fault_v_o,
   output logic [vtag_width_p-1:0]  page_fault_vtag_o
);

   localparam int SEG_W = vtag_width_p / page_table_depth_p;
   localparam int LVL_W = (page_table_depth_p > 1) ? $clog2(page_table_depth_p) : 1;
   localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(page_table_depth_p - 1);

   function automatic logic [SEG_W-1:0] vpn_seg(input logic [vtag_width_p-1:0] vt,
                                                input logic [LVL_W-1:0] lvl);
      return SEG_W'(vt >> (int'(lvl) * SEG_W));
   endfunction

   function automatic logic [paddr_width_p-1:0] pte_addr(input logic [ptag_width_p-1:0] ppn,
                                                         input logic [SEG_W-1:0] seg);
      return paddr_width_p'({ppn, seg, {bp_pte_size_log_lp{1'b0}}});
   endfunction

   bp_ptw_state_e             state_q;
   logic [LVL_W-1:0]          level_q;
   logic [vtag_width_p-1:0]   vtag_q;
   logic                      busy_q;
   logic                      req_v_q;
   logic [paddr_width_p-1:0]  req_addr_q;
   logic                      fill_v_q;
   logic                      fault_v_q;
   logic [vtag_width_p-1:0]   out_vtag_q;
   logic [ptag_width_p-1:0]   fill_ptag_q;

   logic                      dec_fault, dec_leaf;
   logic [ptag_width_p-1:0]   dec_next_ppn, dec_leaf_ptag;

   bp_be_pte_decode #(
      .ptag_width_p (ptag_width_p),
      .vtag_width_p (vtag_width_p),
      .pte_width_p  (pte_width_p),
      .lvl_width_p  (LVL_W),
      .seg_width_p  (SEG_W)
   ) u_decode (
      .pte_i       (mem_resp_data_i),
      .level_i     (level_q),
      .vtag_i      (vtag_q),
      .fault_o     (dec_fault),
      .leaf_o      (dec_leaf),
      .next_ppn_o  (dec_next_ppn),
      .leaf_ptag_o (dec_leaf_ptag)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         level_q     <= '0;
         vtag_q      <= '0;
         busy_q      <= 1'b0;
         req_v_q     <= 1'b0;
         req_addr_q  <= '0;
         fill_v_q    <= 1'b0;
         fault_v_q   <= 1'b0;
         out_vtag_q  <= '0;
         fill_ptag_q <= '0;
      end else begin
         fill_v_q  <= 1'b0;
         fault_v_q <= 1'b0;
         case (state_q)
            IDLE: if (miss_v_i) begin
               vtag_q     <= miss_vtag_i;
               level_q    <= TOP_LVL;
               busy_q     <= 1'b1;
               req_v_q    <= 1'b1;
               req_addr_q <= pte_addr(base_ppn_i, vpn_seg(miss_vtag_i, TOP_LVL));
               state_q    <= SEND;
            end
            SEND: if (mem_req_ready_i) begin
               req_v_q <= 1'b0;
               state_q <= WAIT;
            end
            WAIT: if (mem_resp_v_i) begin
               if (dec_fault) begin
                  fault_v_q  <= 1'b1;
                  out_vtag_q <= vtag_q;
                  state_q    <= FAULT;
               end else if (dec_leaf) begin
                  fill_v_q    <= 1'b1;
                  out_vtag_q  <= vtag_q;
                  fill_ptag_q <= dec_leaf_ptag;
                  state_q     <= FILL;
               end else begin
                  level_q    <= level_q - 1'b1;
                  req_v_q    <= 1'b1;
                  req_addr_q <= pte_addr(dec_next_ppn, vpn_seg(vtag_q, level_q - 1'b1));
                  state_q    <= SEND;
               end
            end
            FILL, FAULT: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o            = busy_q;
   assign mem_req_v_o       = req_v_q;
   assign mem_req_addr_o    = req_addr_q;
   assign tlb_w_v_o         = fill_v_q;
   assign tlb_w_vtag_o      = out_vtag_q;
   assign tlb_w_ptag_o      = fill_ptag_q;
   assign page_fault_v_o    = fault_v_q;
   assign page_fault_vtag_o = out_vtag_q;

endmodule
